hub75_framebuffer: RTL and testbench



---
 rtl/hub75_pkg.sv | 45 ++++
 rtl/hub75_bank_ram.sv | 48 ++++
 rtl/hub75_framebuffer.sv | 167 ++++++++++++++++
 tb/tb_hub75_framebuffer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared constants, FSM encoding and plane extraction for the HUB75 framebuffer.
package hub75_pkg;

    // RGB565 field positions
    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;
    localparam int R_W   = R_MSB - R_LSB + 1;
    localparam int G_W   = G_MSB - G_LSB + 1;
    localparam int B_W   = B_MSB - B_LSB + 1;

    // Default panel geometry
    localparam int DEF_WIDTH      = 32;
    localparam int DEF_HEIGHT     = 32;
    localparam int DEF_COLOR_BITS = 4;

    typedef enum logic [1:0] {
        ST_CLEAR   = 2'd0,
        ST_IDLE    = 2'd1,
        ST_PENDING = 2'd2
    } state_e;

    // One bit-plane of a pixel as {r,g,b}. Each channel keeps only its top
    // color_bits bits; plane 0 is the LSB of that truncated value.
    function automatic logic [2:0] plane_bits(input logic [15:0] pixel,
                                              input int plane,
                                              input int color_bits);
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
        logic [2:0]     res;
        r   = pixel[R_MSB:R_LSB] >> (R_W - color_bits + plane);
        g   = pixel[G_MSB:G_LSB] >> (G_W - color_bits + plane);
        b   = pixel[B_MSB:B_LSB] >> (B_W - color_bits + plane);
        res = 3'b000;
        if (plane < color_bits) begin
            res = {r[0], g[0], b[0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/hub75_bank_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port whose
// output register holds its value while re is low.
module hub75_bank_ram #(
    parameter int DEPTH = 512,
    parameter int AW    = 9,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;

    // Write port; contents are not reset (the top clears them explicitly)
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read data only updates on a read strobe
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    // Read output register, cleared by reset so outputs start at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/hub75_framebuffer.sv
// Double-buffered RGB565 store feeding a HUB75 driver. Host writes go to the
// back bank; the driver reads the front bank; swaps wait for frame_end.
module hub75_framebuffer
    import hub75_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int HEIGHT     = DEF_HEIGHT,
    parameter int COLOR_BITS = DEF_COLOR_BITS,
    localparam int COL_W     = $clog2(WIDTH),
    localparam int ROW_W     = $clog2(HEIGHT / 2),
    localparam int PL_W      = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [COL_W-1:0] wr_x,
    input  logic [ROW_W:0]   wr_y,
    input  logic [15:0]      wr_data,
    input  logic             swap_req,
    output logic             swap_done,
    input  logic             frame_end,
    input  logic             rd_en,
    input  logic [ROW_W-1:0] rd_row,
    input  logic [COL_W-1:0] rd_col,
    input  logic [PL_W-1:0]  rd_plane,
    output logic             rd_valid,
    output logic [2:0]       rgb0,
    output logic [2:0]       rgb1
);

    localparam int DEPTH = WIDTH * HEIGHT / 2;
    localparam int AW    = ROW_W + COL_W;

    state_e          state_q, state_d;
    logic            front_q, front_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic            swap_done_q, swap_done_d;
    logic            rd_valid_q, rd_valid_d;
    logic            rd_bank_q, rd_bank_d;
    logic [PL_W-1:0] rd_plane_q, rd_plane_d;
    logic            do_swap;

    logic            clear_en;
    logic            wr_fire;
    logic [AW-1:0]   waddr;
    logic [15:0]     wdata;
    logic [AW-1:0]   raddr;

    // Indexed [bank][half]; half 0 is the upper half of the panel
    logic [1:0][1:0]       ram_we;
    logic [1:0][1:0][15:0] ram_rdata;

    // Next state, clear walk and swap handling
    always_comb begin
        state_d     = state_q;
        front_d     = front_q;
        clr_cnt_d   = clr_cnt_q;
        swap_done_d = 1'b0;
        wr_ready    = 1'b0;
        do_swap     = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == AW'(DEPTH - 1)) begin
                    clr_cnt_d = '0;
                    state_d   = ST_IDLE;
                end
            end
            ST_IDLE: begin
                wr_ready = 1'b1;
                if (swap_req) begin
                    // A frame boundary in the same cycle swaps immediately
                    if (frame_end) begin
                        do_swap = 1'b1;
                    end else begin
                        state_d = ST_PENDING;
                    end
                end
            end
            ST_PENDING: begin
                if (frame_end) begin
                    do_swap = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
        if (do_swap) begin
            front_d     = ~front_q;
            swap_done_d = 1'b1;
        end
    end

    // Read-side capture: bank and plane are latched with the strobe so the
    // output holds while rd_en is low
    always_comb begin
        rd_valid_d = rd_en;
        rd_bank_d  = rd_bank_q;
        rd_plane_d = rd_plane_q;
        if (rd_en) begin
            rd_bank_d  = front_q;
            rd_plane_d = rd_plane;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            front_q     <= 1'b0;
            clr_cnt_q   <= '0;
            swap_done_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_bank_q   <= 1'b0;
            rd_plane_q  <= '0;
        end else begin
            state_q     <= state_d;
            front_q     <= front_d;
            clr_cnt_q   <= clr_cnt_d;
            swap_done_q <= swap_done_d;
            rd_valid_q  <= rd_valid_d;
            rd_bank_q   <= rd_bank_d;
            rd_plane_q  <= rd_plane_d;
        end
    end

    assign clear_en = (state_q == ST_CLEAR);
    assign wr_fire  = wr_valid && wr_ready;
    assign waddr    = clear_en ? clr_cnt_q : {wr_y[ROW_W-1:0], wr_x};
    assign wdata    = clear_en ? 16'h0000 : wr_data;
    assign raddr    = {rd_row, rd_col};

    for (genvar b = 0; b < 2; b++) begin : g_bank
        for (genvar h = 0; h < 2; h++) begin : g_half
            localparam logic BANK = 1'(b);
            localparam logic HALF = 1'(h);

            // Clear hits every RAM; host writes only the back bank's half
            assign ram_we[b][h] = clear_en ||
                                  (wr_fire && (front_q != BANK) && (wr_y[ROW_W] == HALF));

            hub75_bank_ram #(
                .DEPTH (DEPTH),
                .AW    (AW),
                .DW    (16)
            ) u_ram (
                .clk   (clk),
                .rst   (rst),
                .we    (ram_we[b][h]),
                .waddr (waddr),
                .wdata (wdata),
                .re    (rd_en),
                .raddr (raddr),
                .rdata (ram_rdata[b][h])
            );
        end
    end

    assign rgb0      = plane_bits(ram_rdata[rd_bank_q][0], int'(rd_plane_q), COLOR_BITS);
    assign rgb1      = plane_bits(ram_rdata[rd_bank_q][1], int'(rd_plane_q), COLOR_BITS);
    assign rd_valid  = rd_valid_q;
    assign swap_done = swap_done_q;

endmodule

// File: tb/tb_hub75_framebuffer.sv
// Randomized bench for hub75_framebuffer against a pixel-array model. A second
// instance with COLOR_BITS=3 shares all inputs to exercise plane >= COLOR_BITS.
module tb_hub75_framebuffer;

    localparam int W     = 32;
    localparam int H     = 32;
    localparam int HH    = H / 2;
    localparam int CB    = 4;
    localparam int CB3   = 3;
    localparam int DEPTH = W * H / 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic [4:0]  wr_x = '0;
    logic [4:0]  wr_y = '0;
    logic [15:0] wr_data = '0;
    logic        swap_req = 1'b0;
    logic        frame_end = 1'b0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_row = '0;
    logic [4:0]  rd_col = '0;
    logic [1:0]  rd_plane = '0;

    logic       wr_ready, swap_done, rd_valid;
    logic [2:0] rgb0, rgb1;
    logic       wr_ready_b, swap_done_b, rd_valid_b;
    logic [2:0] rgb0_b, rgb1_b;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    // Model: mdl[bank][y][x], y spans the full panel height
    logic [15:0] mdl [2][H][W];
    int          front;

    hub75_framebuffer #(.WIDTH(W), .HEIGHT(H), .COLOR_BITS(CB)) u_dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .swap_req(swap_req),
        .swap_done(swap_done), .frame_end(frame_end), .rd_en(rd_en),
        .rd_row(rd_row), .rd_col(rd_col), .rd_plane(rd_plane),
        .rd_valid(rd_valid), .rgb0(rgb0), .rgb1(rgb1)
    );

    hub75_framebuffer #(.WIDTH(W), .HEIGHT(H), .COLOR_BITS(CB3)) u_dut3 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready_b),
        .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .swap_req(swap_req),
        .swap_done(swap_done_b), .frame_end(frame_end), .rd_en(rd_en),
        .rd_row(rd_row), .rd_col(rd_col), .rd_plane(rd_plane),
        .rd_valid(rd_valid_b), .rgb0(rgb0_b), .rgb1(rgb1_b)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Truncate each channel to its top cb bits and pick bit 'plane'
    function automatic logic [2:0] exp_bits(logic [15:0] pix, int plane, int cb);
        int r, g, b;
        r = (int'(pix) >> 11) % 32;
        g = (int'(pix) >> 5) % 64;
        b = int'(pix) % 32;
        if (plane >= cb) return 3'b000;
        return {1'((r >> (5 - cb + plane)) % 2), 1'((g >> (6 - cb + plane)) % 2),
                1'((b >> (5 - cb + plane)) % 2)};
    endfunction

    // {rgb0, rgb1, rgb0_b, rgb1_b} expected for a front-bank read
    function automatic logic [11:0] exp_read(int row, int col, int plane);
        logic [15:0] up, lo;
        up = mdl[front][row][col];
        lo = mdl[front][row + HH][col];
        return {exp_bits(up, plane, CB), exp_bits(lo, plane, CB),
                exp_bits(up, plane, CB3), exp_bits(lo, plane, CB3)};
    endfunction

    function automatic void model_clear();
        foreach (mdl[b, y, x]) mdl[b][y][x] = 16'h0000;
        front = 0;
    endfunction

    // Single-cycle read; returns {rd_valid, rd_valid_b, rgb0, rgb1, rgb0_b, rgb1_b}
    task automatic do_read(input int row, input int col, input int plane, output logic [13:0] got);
        rd_en = 1'b1; rd_row = 4'(row); rd_col = 5'(col); rd_plane = 2'(plane);
        step();
        rd_en = 1'b0;
        got = {rd_valid, rd_valid_b, rgb0, rgb1, rgb0_b, rgb1_b};
    endtask

    // Single-cycle write into the back bank (caller makes sure we are idle)
    task automatic do_write(input int x, input int y, input logic [15:0] d);
        wr_valid = 1'b1; wr_x = 5'(x); wr_y = 5'(y); wr_data = d;
        step();
        wr_valid = 1'b0;
        mdl[front ^ 1][y][x] = d;
    endtask

    // swap_req then frame_end; returns swap_done seen right after the toggle
    task automatic do_swap(output logic [1:0] sd);
        swap_req = 1'b1;
        step();
        swap_req = 1'b0; frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        sd = {swap_done, swap_done_b};
        front ^= 1;
    endtask

    // Walk the clear window after releasing reset; counts wrong wr_ready cycles
    task automatic run_clear(output int errs);
        errs = 0;
        rst = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            step();
            if ({wr_ready, wr_ready_b} !== ((k == DEPTH) ? 2'b11 : 2'b00)) errs++;
        end
    endtask

    task automatic test_reset;
        int errs;
        logic [13:0] got;
        rst = 1'b1;
        step(); step();
        tot_cnt++;
        if ({wr_ready, swap_done, rd_valid, rgb0, rgb1, wr_ready_b, swap_done_b, rd_valid_b, rgb0_b, rgb1_b} !== '0)
            $display("FAIL reset_outputs got=%b", {wr_ready, swap_done, rd_valid, rgb0, rgb1});
        else pass_cnt++;
        model_clear();
        run_clear(errs);
        tot_cnt++;
        if (errs !== 0) $display("FAIL clear_window bad_cycles=%0d expected=0", errs);
        else pass_cnt++;
        do_read(5, 7, 3, got);
        tot_cnt++;
        if (got !== 14'b11_000_000_000_000) $display("FAIL reset_read got=%b exp=%b", got, 14'b11_000_000_000_000);
        else pass_cnt++;
        step();
        tot_cnt++;
        if ({rd_valid, rd_valid_b} !== 2'b00) $display("FAIL rd_valid_drop got=%b exp=00", {rd_valid, rd_valid_b});
        else pass_cnt++;
    endtask

    task automatic test_halves;
        logic [1:0]  sd;
        logic [13:0] got;
        tot_cnt++;
        if (wr_ready !== 1'b1) $display("FAIL halves_ready got=%b exp=1", wr_ready);
        else pass_cnt++;
        do_write(3, 2, 16'hF800);
        do_write(3, 18, 16'h07E0);
        do_swap(sd);
        tot_cnt++;
        if (sd !== 2'b11) $display("FAIL halves_swap_done got=%b exp=11", sd);
        else pass_cnt++;
        step();
        tot_cnt++;
        if (swap_done !== 1'b0) $display("FAIL halves_swap_pulse got=%b exp=0", swap_done);
        else pass_cnt++;
        do_read(2, 3, 3, got);
        tot_cnt++;
        if (got !== {2'b11, exp_read(2, 3, 3)}) $display("FAIL halves_read got=%b exp=%b", got, {2'b11, exp_read(2, 3, 3)});
        else pass_cnt++;
        tot_cnt++;
        if (got[11:6] !== 6'b100_010) $display("FAIL halves_colors got=%b exp=100010", got[11:6]);
        else pass_cnt++;
    endtask

    task automatic test_planes;
        logic [1:0]  sd;
        logic [13:0] got;
        int x, r;
        x = $urandom_range(0, W - 1);
        r = $urandom_range(0, HH - 1);
        do_write(x, r, 16'hFFFF);
        do_write(x, r + HH, 16'hFFFF);
        do_swap(sd);
        for (int p = 0; p < 4; p++) begin
            do_read(r, x, p, got);
            tot_cnt++;
            if (got !== {2'b11, 6'b111_111, (p < CB3) ? 6'b111_111 : 6'b000_000})
                $display("FAIL plane%0d got=%b exp=%b", p, got, {2'b11, exp_read(r, x, p)});
            else pass_cnt++;
        end
    endtask

    task automatic test_random(input int nwr, input int nrd);
        logic [1:0]  sd;
        logic [13:0] got;
        int row, col, pl;
        for (int i = 0; i < nwr; i++)
            do_write($urandom_range(0, W - 1), $urandom_range(0, H - 1), 16'($urandom));
        do_swap(sd);
        tot_cnt++;
        if (sd !== 2'b11) $display("FAIL random_swap_done got=%b exp=11", sd);
        else pass_cnt++;
        for (int i = 0; i < nrd; i++) begin
            row = $urandom_range(0, HH - 1);
            col = $urandom_range(0, W - 1);
            pl  = $urandom_range(0, 3);
            do_read(row, col, pl, got);
            tot_cnt++;
            if (got !== {2'b11, exp_read(row, col, pl)})
                $display("FAIL random_read r%0d c%0d p%0d got=%b exp=%b", row, col, pl, got, {2'b11, exp_read(row, col, pl)});
            else pass_cnt++;
        end
    endtask

    task automatic test_pending;
        logic [1:0]  sd;
        logic [13:0] got;
        logic [11:0] e_old;
        int x, r, pl, errs, pulses;
        x  = $urandom_range(0, W - 1);
        r  = $urandom_range(0, HH - 1);
        pl = $urandom_range(0, 2);
        do_write(x, r, 16'h0000);
        do_swap(sd);
        do_write(x, r, 16'hFFFF);
        e_old = exp_read(r, x, pl);
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        errs = 0;
        rd_row = 4'(r); rd_col = 5'(x); rd_plane = 2'(pl);
        for (int c = 0; c < 100; c++) begin
            swap_req = (c == 50);
            rd_en = 1'b1;
            step();
            if (wr_ready !== 1'b0 || swap_done !== 1'b0) errs++;
            if ({rgb0, rgb1, rgb0_b, rgb1_b} !== e_old) errs++;
        end
        rd_en = 1'b0; swap_req = 1'b0;
        tot_cnt++;
        if (errs !== 0) $display("FAIL pending_hold bad_cycles=%0d expected=0", errs);
        else pass_cnt++;
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        front ^= 1;
        tot_cnt++;
        if ({swap_done, wr_ready} !== 2'b11) $display("FAIL pending_swap got=%b exp=11", {swap_done, wr_ready});
        else pass_cnt++;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            frame_end = (k == 3);
            step();
            if (swap_done === 1'b1) pulses++;
        end
        frame_end = 1'b0;
        tot_cnt++;
        if (pulses !== 0) $display("FAIL pending_extra_pulses got=%0d exp=0", pulses);
        else pass_cnt++;
        do_read(r, x, pl, got);
        tot_cnt++;
        if (got !== {2'b11, exp_read(r, x, pl)}) $display("FAIL pending_read got=%b exp=%b", got, {2'b11, exp_read(r, x, pl)});
        else pass_cnt++;
    endtask

    task automatic test_same_cycle;
        logic [13:0] got;
        logic [15:0] d;
        int x, r;
        x = $urandom_range(0, W - 1);
        r = $urandom_range(0, HH - 1);
        d = 16'($urandom) | 16'h8421;
        tot_cnt++;
        if (wr_ready !== 1'b1) $display("FAIL same_ready got=%b exp=1", wr_ready);
        else pass_cnt++;
        wr_valid = 1'b1; wr_x = 5'(x); wr_y = 5'(r); wr_data = d;
        swap_req = 1'b1; frame_end = 1'b1;
        step();
        wr_valid = 1'b0; swap_req = 1'b0; frame_end = 1'b0;
        mdl[front ^ 1][r][x] = d;
        front ^= 1;
        tot_cnt++;
        if (swap_done !== 1'b1) $display("FAIL same_swap_done got=%b exp=1", swap_done);
        else pass_cnt++;
        for (int p = 0; p < 4; p++) begin
            do_read(r, x, p, got);
            tot_cnt++;
            if (got[11:9] !== exp_bits(d, p, CB) || got !== {2'b11, exp_read(r, x, p)})
                $display("FAIL same_read p%0d got=%b exp=%b", p, got, {2'b11, exp_read(r, x, p)});
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_pending;
        logic [1:0]  sd;
        logic [13:0] got;
        int x, r, errs;
        x = $urandom_range(0, W - 1);
        r = $urandom_range(0, HH - 1);
        do_write(x, r, 16'hFFFF);
        do_swap(sd);
        do_read(r, x, 0, got);
        tot_cnt++;
        if (got !== {2'b11, exp_read(r, x, 0)}) $display("FAIL rstp_visible got=%b exp=%b", got, {2'b11, exp_read(r, x, 0)});
        else pass_cnt++;
        do_write(x, r, 16'h1234);
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        rst = 1'b1; frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        model_clear();
        tot_cnt++;
        if ({swap_done, wr_ready} !== 2'b00) $display("FAIL rstp_no_swap got=%b exp=00", {swap_done, wr_ready});
        else pass_cnt++;
        run_clear(errs);
        tot_cnt++;
        if (errs !== 0) $display("FAIL rstp_clear_window bad_cycles=%0d expected=0", errs);
        else pass_cnt++;
        do_read(r, x, 0, got);
        tot_cnt++;
        if (got !== 14'b11_000_000_000_000) $display("FAIL rstp_cleared got=%b exp=%b", got, 14'b11_000_000_000_000);
        else pass_cnt++;
        step();
        tot_cnt++;
        if (swap_done !== 1'b0) $display("FAIL rstp_late_swap got=%b exp=0", swap_done);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_halves();
        test_planes();
        test_random(40, 30);
        test_pending();
        test_random(60, 30);
        test_same_cycle();
        test_reset_pending();
        test_random(40, 30);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
